// File: rtl/mem_pkg.sv
// Shared definitions for the multicycle memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/mem_word_array.sv
// Single-port word array: synchronous write, registered read that holds
// its value until the next read strobe.
module mem_word_array #(
  parameter int MEM_DEPTH = 1024,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  word_idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Commit writes and capture read words on the access edge.
  always_ff @(posedge clk) begin
    if (we) mem[word_idx] <= wdata;
    if (re) rdata <= mem[word_idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Multicycle memory slave: latches a request, waits LATENCY cycles in
// total, performs the array access on the edge into DONE, then pulses
// mem_ready. Illegal requests get a one-cycle mem_error pulse instead.
module mem_responder
  import mem_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter int LATENCY    = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           din,
  output logic [31:0]           dout,
  output logic                  mem_ready,
  output logic                  mem_busy,
  output logic                  mem_error
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_responder: LATENCY must be within 1..15");
  end

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       din_q;
  logic              wr_q;
  logic              dout_vld;
  logic              req, bad, commit, commit_wr, we, re;
  logic [IDX_W-1:0]  word_idx;
  logic [31:0]       wdata, rdata;

  assign req = mem_read | mem_write;
  assign bad = (mem_read & mem_write) | (addr[1:0] != 2'b00) |
               ({2'b00, addr[ADDR_WIDTH-1:2]} >= DEPTH_A);

  // The access happens on the edge that enters DONE; with LATENCY==1 that
  // edge is the sampling edge itself, so the live inputs are used directly.
  assign commit    = ((state == IDLE) && req && !bad && (LATENCY == 1)) ||
                     ((state == WAIT) && (cnt == CNT_W'(1)));
  assign commit_wr = (state == IDLE) ? mem_write : wr_q;
  assign we        = commit & commit_wr;
  assign re        = commit & ~commit_wr;
  assign word_idx  = (state == IDLE) ? addr[IDX_W+1:2] : idx_q;
  assign wdata     = (state == IDLE) ? din : din_q;

  mem_word_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .DATA_W    (32),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk      (clk),
    .we       (we),
    .re       (re),
    .word_idx (word_idx),
    .wdata    (wdata),
    .rdata    (rdata)
  );

  // Until the first read after reset, dout reads as zero.
  assign dout = dout_vld ? rdata : 32'h0;

  // State, countdown and read-valid flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      dout_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (re) dout_vld <= 1'b1;
    end
  end

  // Request capture so the requester may drop its strobes after sampling.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      idx_q <= addr[IDX_W+1:2];
      din_q <= din;
      wr_q  <= mem_write;
    end
  end

  // Next-state, countdown and status outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_ready = 1'b0;
    mem_busy  = 1'b0;
    mem_error = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (bad) begin
            state_nxt = ERR;
          end else if (LATENCY == 1) begin
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        mem_busy = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = DONE;
        else                  cnt_nxt   = cnt - CNT_W'(1);
      end
      DONE: begin
        mem_busy  = 1'b1;
        mem_ready = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        mem_error = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: three responders (LATENCY 2, 1, 4) share a clock.
// Stimulus pushes expected completions; per-instance monitors pop and
// compare kind, arrival cycle and dout whenever ready or error fires.
module tb_mem_responder;

  typedef struct {
    bit          err;
    logic [31:0] d;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset     [3];
  logic        mem_read  [3];
  logic        mem_write [3];
  logic [31:0] addr      [3];
  logic [31:0] din       [3];
  logic [31:0] dout      [3];
  logic        mem_ready [3];
  logic        mem_busy  [3];
  logic        mem_error [3];

  int   lat [3] = '{2, 1, 4};
  exp_t sb  [3][$];
  int   cyc   = 0;
  int   pass  = 0;
  int   total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    mem_responder #(.MEM_DEPTH(1024), .LATENCY(L), .ADDR_WIDTH(32)) u_dut (
      .clk       (clk),
      .reset     (reset[g]),
      .mem_read  (mem_read[g]),
      .mem_write (mem_write[g]),
      .addr      (addr[g]),
      .din       (din[g]),
      .dout      (dout[g]),
      .mem_ready (mem_ready[g]),
      .mem_busy  (mem_busy[g]),
      .mem_error (mem_error[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_mon
    exp_t e;
    always @(negedge clk) begin
      if (mem_ready[g] || mem_error[g]) begin
        if (sb[g].size() == 0) begin
          check($sformatf("unexpected_resp[%0d]", g), {30'd0, mem_error[g], mem_ready[g]}, 32'd0);
        end else begin
          e = sb[g].pop_front();
          check($sformatf("resp_kind[%0d]", g), {30'd0, mem_error[g], mem_ready[g]},
                e.err ? 32'd2 : 32'd1);
          check($sformatf("resp_cycle[%0d]", g), cyc, e.cyc);
          check($sformatf("dout[%0d]", g), dout[g], e.d);
        end
      end
    end
  end

  task automatic drain(input int g);
    for (int i = 0; i < 40 && sb[g].size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check($sformatf("drain_pending[%0d]", g), sb[g].size(), 32'd0);
    sb[g].delete();
  endtask

  // One request held for `hold` cycles; expects a single response.
  task automatic xact(input int g, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input bit e, input logic [31:0] xd,
                      input int hold = 1);
    exp_t x;
    @(negedge clk);
    mem_read[g]  = rd;
    mem_write[g] = wr;
    addr[g]      = a;
    din[g]       = d;
    x.err = e;
    x.d   = xd;
    x.cyc = cyc + (e ? 1 : lat[g]);
    sb[g].push_back(x);
    repeat (hold) @(negedge clk);
    mem_read[g]  = 1'b0;
    mem_write[g] = 1'b0;
    drain(g);
  endtask

  initial begin
    exp_t x;
    int   c;
    for (int g = 0; g < 3; g++) begin
      reset[g] = 1'b1; mem_read[g] = 1'b0; mem_write[g] = 1'b0;
      addr[g] = '0; din[g] = '0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst_ready[%0d]", g), {31'd0, mem_ready[g]}, 32'd0);
      check($sformatf("rst_busy[%0d]", g),  {31'd0, mem_busy[g]},  32'd0);
      check($sformatf("rst_error[%0d]", g), {31'd0, mem_error[g]}, 32'd0);
      check($sformatf("rst_dout[%0d]", g),  dout[g], 32'd0);
      reset[g] = 1'b0;
    end

    // LATENCY=2
    xact(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0);
    xact(0, 1, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF);
    xact(0, 0, 1, 32'h08, 32'hCAFEF00D, 0, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    check("dout_held_idle", dout[0], 32'hDEADBEEF);
    xact(0, 1, 0, 32'h08, 32'h0,        0, 32'hCAFEF00D);
    xact(0, 1, 0, 32'h13, 32'h0,        1, 32'hCAFEF00D);
    xact(0, 1, 0, 32'h1000, 32'h0,      1, 32'hCAFEF00D);
    xact(0, 0, 1, 32'h20, 32'h11112222, 0, 32'hCAFEF00D);
    xact(0, 1, 1, 32'h20, 32'hFFFFFFFF, 1, 32'hCAFEF00D);
    xact(0, 1, 0, 32'h20, 32'h0,        0, 32'h11112222);
    xact(0, 1, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF, 2);
    repeat (4) @(negedge clk);

    // LATENCY=1
    xact(1, 0, 1, 32'h0, 32'h00500093, 0, 32'h0);
    xact(1, 1, 0, 32'h0, 32'h0,        0, 32'h00500093);
    @(negedge clk);
    mem_read[1] = 1'b1; addr[1] = 32'h0;
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      x.err = 1'b0; x.d = 32'h00500093; x.cyc = c + 1 + 2 * k;
      sb[1].push_back(x);
    end
    repeat (5) @(negedge clk);
    mem_read[1] = 1'b0;
    drain(1);

    // LATENCY=4 with reset in WAIT
    xact(2, 0, 1, 32'h44, 32'hA5A50001, 0, 32'h0);
    xact(2, 1, 0, 32'h44, 32'h0,        0, 32'hA5A50001);
    xact(2, 0, 1, 32'h40, 32'h0,        0, 32'hA5A50001);
    @(negedge clk);
    mem_write[2] = 1'b1; addr[2] = 32'h40; din[2] = 32'h12345678;
    @(negedge clk);
    mem_write[2] = 1'b0;
    check("busy_in_wait", {31'd0, mem_busy[2]}, 32'd1);
    @(negedge clk);
    reset[2] = 1'b1;
    #1;
    check("midrst_ready", {31'd0, mem_ready[2]}, 32'd0);
    check("midrst_busy",  {31'd0, mem_busy[2]},  32'd0);
    check("midrst_error", {31'd0, mem_error[2]}, 32'd0);
    check("midrst_dout",  dout[2], 32'd0);
    @(negedge clk);
    reset[2] = 1'b0;
    repeat (6) @(negedge clk);
    xact(2, 1, 0, 32'h40, 32'h0, 0, 32'h0);

    repeat (6) @(negedge clk);
    for (int g = 0; g < 3; g++) check($sformatf("final_queue[%0d]", g), sb[g].size(), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
